// File: rtl/v810_pkg.sv
// V810 shared types: PSW/ECR layouts, system register selects, sequencer enums.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro: V810_ADTRE_EN (keeps PSW.AE writable when defined).
package v810_pkg;

  typedef struct packed {
    logic [11:0] rfu_hi;
    logic [3:0]  i;
    logic        np;
    logic        ep;
    logic        ae;
    logic        id;
    logic [1:0]  rfu_lo;
    logic        fro;
    logic        fiv;
    logic        fzd;
    logic        fov;
    logic        fud;
    logic        fpr;
    logic        cy;
    logic        ov;
    logic        s;
    logic        z;
  } psw_t;

  typedef struct packed {
    logic [15:0] fecc;
    logic [15:0] eicc;
  } ecr_t;

  typedef struct packed {
    logic cy;
    logic ov;
    logic s;
    logic z;
  } aluflags_t;

  typedef enum logic [4:0] {
    SR_EIPC  = 5'd0,
    SR_EIPSW = 5'd1,
    SR_FEPC  = 5'd2,
    SR_FEPSW = 5'd3,
    SR_ECR   = 5'd4,
    SR_PSW   = 5'd5,
    SR_PIR   = 5'd6,
    SR_TKCW  = 5'd7,
    SR_CHCW  = 5'd24,
    SR_ADTRE = 5'd25
  } sr_sel_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_VECTOR, ST_HALT} seq_state_t;
  typedef enum logic [1:0] {KIND_EXC, KIND_IRQ, KIND_ADTRE} exc_kind_t;

  localparam logic [31:0] PSW_RESET     = 32'h0000_8000;
  localparam logic [31:0] ECR_RESET     = 32'h0000_FFF0;
  localparam logic [15:0] IRQ_CODE_BASE = 16'hFE00;
  localparam logic [15:0] ADTRE_CODE    = 16'hFFC0;
  localparam logic [31:0] VECTOR_BASE   = 32'hFFFF_0000;

  // Writable PSW bits; RFU fields always read back as zero, and AE only
  // exists when the address trap is built in.
`ifdef V810_ADTRE_EN
  localparam logic [31:0] PSW_WMASK = 32'h000F_F3FF;
`else
  localparam logic [31:0] PSW_WMASK = 32'h000F_D3FF;
`endif

  function automatic psw_t psw_wmask(input logic [31:0] d);
    return psw_t'(d & PSW_WMASK);
  endfunction

endpackage

// File: rtl/v810_exc_seq.sv
// V810 exception sequencer: arbitrates EXC/ADTRE > RETI > IRQ, runs IDLE/SAVE/VECTOR/HALT.
// Latency: entry redirect 2 cycles after request; RETI redirect 1 cycle after strobe.
// Backpressure: busy high outside IDLE; losing requests are not acked and must be held.
// Ports: clk/rst_n/ce; request inputs; PSW control bits; save_* controls to the
// register file; registered redir/redir_pc/ack/fatal; busy/idle state decodes.
module v810_exc_seq
  import v810_pkg::*;
#(
  parameter int          NUM_IRQ_LEVELS = 16,
  parameter logic [31:0] DUP_VECTOR     = 32'hFFFF_FFD0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        exc_req,
  input  logic [15:0] exc_code,
  input  logic        adtre_hit,
  input  logic        irq_req,
  input  logic [3:0]  irq_level,
  input  logic [31:0] cur_pc,
  input  logic        reti,
  input  logic        psw_np,
  input  logic        psw_ep,
  input  logic        psw_id,
  input  logic [3:0]  psw_i,
  input  logic [31:0] reti_pc,
  output logic        idle,
  output logic        reti_take,
  output logic        save_norm,
  output logic        save_dup,
  output logic [31:0] save_pc,
  output logic [15:0] save_code,
  output logic        save_irq,
  output logic [3:0]  save_lvl,
  output logic        redir,
  output logic [31:0] redir_pc,
  output logic        ack,
  output logic        busy,
  output logic        fatal
);

  seq_state_t  state;
  exc_kind_t   lat_kind;
  logic [31:0] lat_pc;
  logic [15:0] lat_code;
  logic [3:0]  lat_lvl;
  logic        irq_ok;
  logic        in_save;

  assign irq_ok = irq_req && !psw_id && !psw_ep && !psw_np &&
                  (irq_level >= psw_i) &&
                  ({1'b0, irq_level} < 5'(NUM_IRQ_LEVELS));

  assign idle      = (state == ST_IDLE);
  assign busy      = !idle;
  assign in_save   = ce && (state == ST_SAVE);
  assign reti_take = ce && idle && !exc_req && !adtre_hit && reti;
  // SAVE looks at the live PSW, so an LDSR from the request cycle is honoured.
  assign save_norm = in_save && !psw_np && !psw_ep;
  assign save_dup  = in_save && !psw_np && psw_ep;
  assign save_pc   = lat_pc;
  assign save_code = lat_code;
  assign save_irq  = (lat_kind == KIND_IRQ);
  assign save_lvl  = lat_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lat_kind <= KIND_EXC;
      lat_pc   <= '0;
      lat_code <= '0;
      lat_lvl  <= '0;
      redir    <= 1'b0;
      redir_pc <= '0;
      ack      <= 1'b0;
      fatal    <= 1'b0;
    end else if (ce) begin
      redir <= 1'b0;
      ack   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (exc_req) begin
            lat_kind <= KIND_EXC;
            lat_code <= exc_code;
            lat_pc   <= cur_pc;
            state    <= ST_SAVE;
          end else if (adtre_hit) begin
            lat_kind <= KIND_ADTRE;
            lat_code <= ADTRE_CODE;
            lat_pc   <= cur_pc;
            state    <= ST_SAVE;
          end else if (reti) begin
            redir    <= 1'b1;
            redir_pc <= reti_pc;
          end else if (irq_ok) begin
            lat_kind <= KIND_IRQ;
            lat_code <= IRQ_CODE_BASE | {8'h00, irq_level, 4'h0};
            lat_lvl  <= irq_level;
            lat_pc   <= cur_pc;
            state    <= ST_SAVE;
          end
        end
        ST_SAVE: begin
          if (psw_np) begin
            state <= ST_HALT;
            fatal <= 1'b1;
          end else begin
            redir    <= 1'b1;
            ack      <= 1'b1;
            redir_pc <= psw_ep ? DUP_VECTOR : (VECTOR_BASE | {16'h0000, lat_code});
            state    <= ST_VECTOR;
          end
        end
        ST_VECTOR: state <= ST_IDLE;
        default:   state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: rtl/v810_sysreg_file.sv
// V810 system register file: EIPC/EIPSW/FEPC/FEPSW/ECR/PSW/CHCW(/ADTRE), PIR/TKCW constants.
// Latency: STSR combinational; LDSR/flags commit next edge; redirects from v810_exc_seq.
// Backpressure: BUSY stalls the core; LDSR/flag writes only land in IDLE with CE high.
// Optional feature macro: V810_ADTRE_EN (ADTRE register and address-trap comparator).
// Ports: CLK/RESn/CE; SR_SEL/SR_WR/SR_WDATA/SR_RDATA; FLG_WE/FLG; EXC_REQ/EXC_CODE;
// IRQ_REQ/IRQ_LEVEL; CUR_PC; RETI; REDIR/REDIR_PC/ACK/BUSY/FATAL; PSW.
module v810_sysreg_file
  import v810_pkg::*;
#(
  parameter int          NUM_IRQ_LEVELS = 16,
  parameter logic [31:0] PIR_VALUE      = 32'h0000_5346,
  parameter logic [31:0] TKCW_VALUE     = 32'h0000_00E0,
  parameter logic [31:0] DUP_VECTOR     = 32'hFFFF_FFD0
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic [4:0]  SR_SEL,
  input  logic        SR_WR,
  input  logic [31:0] SR_WDATA,
  output logic [31:0] SR_RDATA,
  input  logic        FLG_WE,
  input  logic [3:0]  FLG,
  input  logic        EXC_REQ,
  input  logic [15:0] EXC_CODE,
  input  logic        IRQ_REQ,
  input  logic [3:0]  IRQ_LEVEL,
  input  logic [31:0] CUR_PC,
  input  logic        RETI,
  output logic        REDIR,
  output logic [31:0] REDIR_PC,
  output logic        ACK,
  output logic        BUSY,
  output logic        FATAL,
  output logic [31:0] PSW
);

  psw_t        psw_q;
  ecr_t        ecr_q;
  aluflags_t   flg;
  logic [31:0] eipc_q, eipsw_q, fepc_q, fepsw_q, chcw_q;
  logic [31:0] reti_pc;
  logic        adtre_hit, seq_idle, reti_take, save_norm, save_dup, save_irq;
  logic [31:0] save_pc;
  logic [15:0] save_code;
  logic [3:0]  save_lvl;

  assign flg     = aluflags_t'(FLG);
  assign PSW     = psw_q;
  assign reti_pc = psw_q.np ? fepc_q : eipc_q;

`ifdef V810_ADTRE_EN
  logic [31:0] adtre_q;
  // Address trap only fires when nothing else is asking this cycle.
  assign adtre_hit = psw_q.ae && (CUR_PC == adtre_q) && !EXC_REQ && !RETI && !IRQ_REQ;
`else
  assign adtre_hit = 1'b0;
`endif

  v810_exc_seq #(
    .NUM_IRQ_LEVELS (NUM_IRQ_LEVELS),
    .DUP_VECTOR     (DUP_VECTOR)
  ) u_seq (
    .clk       (CLK),
    .rst_n     (RESn),
    .ce        (CE),
    .exc_req   (EXC_REQ),
    .exc_code  (EXC_CODE),
    .adtre_hit (adtre_hit),
    .irq_req   (IRQ_REQ),
    .irq_level (IRQ_LEVEL),
    .cur_pc    (CUR_PC),
    .reti      (RETI),
    .psw_np    (psw_q.np),
    .psw_ep    (psw_q.ep),
    .psw_id    (psw_q.id),
    .psw_i     (psw_q.i),
    .reti_pc   (reti_pc),
    .idle      (seq_idle),
    .reti_take (reti_take),
    .save_norm (save_norm),
    .save_dup  (save_dup),
    .save_pc   (save_pc),
    .save_code (save_code),
    .save_irq  (save_irq),
    .save_lvl  (save_lvl),
    .redir     (REDIR),
    .redir_pc  (REDIR_PC),
    .ack       (ACK),
    .busy      (BUSY),
    .fatal     (FATAL)
  );

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      psw_q   <= psw_t'(PSW_RESET);
      ecr_q   <= ecr_t'(ECR_RESET);
      eipc_q  <= '0;
      eipsw_q <= '0;
      fepc_q  <= '0;
      fepsw_q <= '0;
      chcw_q  <= '0;
`ifdef V810_ADTRE_EN
      adtre_q <= '0;
`endif
    end else if (CE) begin
      if (seq_idle) begin
        if (FLG_WE) begin
          psw_q.cy <= flg.cy;
          psw_q.ov <= flg.ov;
          psw_q.s  <= flg.s;
          psw_q.z  <= flg.z;
        end
        // LDSR is sequenced after the flag update so it wins on PSW.
        if (SR_WR) begin
          case (SR_SEL)
            SR_EIPC:  eipc_q  <= SR_WDATA;
            SR_EIPSW: eipsw_q <= SR_WDATA;
            SR_FEPC:  fepc_q  <= SR_WDATA;
            SR_FEPSW: fepsw_q <= SR_WDATA;
            SR_PSW:   psw_q   <= psw_wmask(SR_WDATA);
            SR_CHCW:  chcw_q  <= SR_WDATA;
`ifdef V810_ADTRE_EN
            SR_ADTRE: adtre_q <= {SR_WDATA[31:1], 1'b0};
`endif
            default: ;
          endcase
        end
        // Restored PSW is masked too, so RFU/AE garbage in a saved copy never leaks back.
        if (reti_take) psw_q <= psw_wmask(psw_q.np ? fepsw_q : eipsw_q);
      end else if (save_norm) begin
        eipc_q     <= save_pc;
        eipsw_q    <= psw_q;
        ecr_q.eicc <= save_code;
        psw_q.ep   <= 1'b1;
        psw_q.id   <= 1'b1;
        psw_q.ae   <= 1'b0;
        if (save_irq) psw_q.i <= (save_lvl == 4'hF) ? 4'hF : save_lvl + 4'd1;
      end else if (save_dup) begin
        fepc_q     <= save_pc;
        fepsw_q    <= psw_q;
        ecr_q.fecc <= save_code;
        psw_q.np   <= 1'b1;
        psw_q.id   <= 1'b1;
        psw_q.ae   <= 1'b0;
      end
    end
  end

  always_comb begin
    SR_RDATA = '0;
    case (SR_SEL)
      SR_EIPC:  SR_RDATA = eipc_q;
      SR_EIPSW: SR_RDATA = eipsw_q;
      SR_FEPC:  SR_RDATA = fepc_q;
      SR_FEPSW: SR_RDATA = fepsw_q;
      SR_ECR:   SR_RDATA = ecr_q;
      SR_PSW:   SR_RDATA = psw_q;
      SR_PIR:   SR_RDATA = PIR_VALUE;
      SR_TKCW:  SR_RDATA = TKCW_VALUE;
      SR_CHCW:  SR_RDATA = chcw_q;
`ifdef V810_ADTRE_EN
      SR_ADTRE: SR_RDATA = adtre_q;
`endif
      default:  SR_RDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_v810_sysreg_file.sv
// Directed bench for v810_sysreg_file: register access, entry/return sequencing, fatal halt.
// Latency: n/a.
// Backpressure: n/a.
module tb_v810_sysreg_file;
  import v810_pkg::*;

  logic        clk = 1'b0;
  logic        RESn = 1'b0;
  logic        CE = 1'b1;
  logic [4:0]  SR_SEL = 5'd0;
  logic        SR_WR = 1'b0;
  logic [31:0] SR_WDATA = '0;
  logic [31:0] SR_RDATA;
  logic        FLG_WE = 1'b0;
  logic [3:0]  FLG = '0;
  logic        EXC_REQ = 1'b0;
  logic [15:0] EXC_CODE = '0;
  logic        IRQ_REQ = 1'b0;
  logic [3:0]  IRQ_LEVEL = '0;
  logic [31:0] CUR_PC = 32'h0700_0000;
  logic        RETI = 1'b0;
  logic        REDIR, ACK, BUSY, FATAL;
  logic [31:0] REDIR_PC, PSW;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;
  int redir_cnt = 0;
  int ack_snap, redir_snap;
  logic ok;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ACK)   ack_cnt++;
    if (REDIR) redir_cnt++;
  end

  v810_sysreg_file dut (
    .CLK(clk), .RESn(RESn), .CE(CE),
    .SR_SEL(SR_SEL), .SR_WR(SR_WR), .SR_WDATA(SR_WDATA), .SR_RDATA(SR_RDATA),
    .FLG_WE(FLG_WE), .FLG(FLG),
    .EXC_REQ(EXC_REQ), .EXC_CODE(EXC_CODE),
    .IRQ_REQ(IRQ_REQ), .IRQ_LEVEL(IRQ_LEVEL),
    .CUR_PC(CUR_PC), .RETI(RETI),
    .REDIR(REDIR), .REDIR_PC(REDIR_PC), .ACK(ACK), .BUSY(BUSY), .FATAL(FATAL),
    .PSW(PSW)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sr_chk(input string tag, input logic [4:0] sel, input logic [31:0] exp);
    @(negedge clk);
    SR_SEL = sel;
    #1;
    check(tag, SR_RDATA, exp);
  endtask

  task automatic sr_wr(input logic [4:0] sel, input logic [31:0] data);
    SR_SEL   = sel;
    SR_WDATA = data;
    SR_WR    = 1'b1;
    tick();
    SR_WR    = 1'b0;
  endtask

  task automatic wait_redir(input string tag, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (REDIR) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_redir", {31'd0, REDIR}, 32'd0);
    check("rst_fatal", {31'd0, FATAL}, 32'd0);
    check("rst_psw_port", PSW, 32'h0000_8000);
    @(negedge clk);
    RESn = 1'b1;
    sr_chk("rst_psw", SR_PSW, 32'h0000_8000);
    sr_chk("rst_ecr", SR_ECR, 32'h0000_FFF0);
    sr_chk("rst_pir", SR_PIR, 32'h0000_5346);
    sr_chk("rst_tkcw", SR_TKCW, 32'h0000_00E0);
    sr_chk("unimpl_rd", 5'd12, 32'h0);

    // PSW masking, ignored writes, flags
    sr_wr(SR_PSW, 32'hFFFF_FFFF);
`ifdef V810_ADTRE_EN
    sr_chk("psw_mask", SR_PSW, 32'h000F_F3FF);
`else
    sr_chk("psw_mask", SR_PSW, 32'h000F_D3FF);
`endif
    sr_wr(SR_PSW, 32'h0);
    sr_wr(SR_ECR, 32'h1234_5678);
    sr_chk("ecr_ro", SR_ECR, 32'h0000_FFF0);
    sr_wr(SR_PIR, 32'h1111_1111);
    sr_chk("pir_ro", SR_PIR, 32'h0000_5346);
    sr_wr(SR_CHCW, 32'h0000_0002);
    sr_chk("chcw_rw", SR_CHCW, 32'h0000_0002);
    FLG = 4'b1010; FLG_WE = 1'b1; tick(); FLG_WE = 1'b0;
    sr_chk("flags", SR_PSW, 32'h0000_000A);
    FLG = 4'b1111; FLG_WE = 1'b1;
    sr_wr(SR_PSW, 32'h0000_0005);
    FLG_WE = 1'b0;
    sr_chk("ldsr_beats_flg", SR_PSW, 32'h0000_0005);
    sr_wr(SR_PSW, 32'h0);

    // Normal exception entry, exact latency
    EXC_REQ = 1'b1; EXC_CODE = 16'hFF60; CUR_PC = 32'h0700_0100;
    tick();
    EXC_REQ = 1'b0;
    check("exc_busy1", {31'd0, BUSY}, 32'd1);
    check("exc_noredir1", {31'd0, REDIR}, 32'd0);
    tick();
    check("exc_redir", {31'd0, REDIR}, 32'd1);
    check("exc_ack", {31'd0, ACK}, 32'd1);
    check("exc_pc", REDIR_PC, 32'hFFFF_FF60);
    tick();
    check("exc_redir_1cyc", {31'd0, REDIR}, 32'd0);
    check("exc_idle", {31'd0, BUSY}, 32'd0);
    sr_chk("exc_eipc", SR_EIPC, 32'h0700_0100);
    sr_chk("exc_ecr", SR_ECR, 32'h0000_FF60);
    sr_chk("exc_psw", SR_PSW, 32'h0000_5000);
    sr_chk("exc_eipsw", SR_EIPSW, 32'h0);

    // Interrupts: masked level, accepted level, saturation at 15
    sr_wr(SR_PSW, 32'h0003_0000);
    ack_snap = ack_cnt;
    IRQ_REQ = 1'b1; IRQ_LEVEL = 4'd2; CUR_PC = 32'h0700_0140;
    repeat (4) tick();
    check("irq_low_busy", {31'd0, BUSY}, 32'd0);
    check("irq_low_noack", ack_cnt, ack_snap);
    IRQ_LEVEL = 4'd4;
    wait_redir("irq4_seen", ok);
    check("irq4_pc", REDIR_PC, 32'hFFFF_FE40);
    check("irq4_ack", {31'd0, ACK}, 32'd1);
    IRQ_REQ = 1'b0;
    tick();
    sr_chk("irq4_psw", SR_PSW, 32'h0005_5000);
    sr_chk("irq4_eipsw", SR_EIPSW, 32'h0003_0000);
    sr_chk("irq4_ecr", SR_ECR, 32'h0000_FE40);
    sr_wr(SR_PSW, 32'h0003_0000);
    IRQ_REQ = 1'b1; IRQ_LEVEL = 4'd15; CUR_PC = 32'h0700_0180;
    wait_redir("irq15_seen", ok);
    check("irq15_pc", REDIR_PC, 32'hFFFF_FEF0);
    IRQ_REQ = 1'b0;
    tick();
    sr_chk("irq15_psw", SR_PSW, 32'h000F_5000);

    // Duplexed exception then two RETIs
    EXC_REQ = 1'b1; EXC_CODE = 16'hFF80; CUR_PC = 32'h0700_0200;
    tick();
    EXC_REQ = 1'b0;
    wait_redir("dup_seen", ok);
    check("dup_pc", REDIR_PC, 32'hFFFF_FFD0);
    tick();
    sr_chk("dup_fepc", SR_FEPC, 32'h0700_0200);
    sr_chk("dup_fepsw", SR_FEPSW, 32'h000F_5000);
    sr_chk("dup_ecr", SR_ECR, 32'hFF80_FEF0);
    sr_chk("dup_psw", SR_PSW, 32'h000F_D000);
    ack_snap = ack_cnt;
    RETI = 1'b1; tick(); RETI = 1'b0;
    check("reti1_redir", {31'd0, REDIR}, 32'd1);
    check("reti1_pc", REDIR_PC, 32'h0700_0200);
    check("reti1_busy", {31'd0, BUSY}, 32'd0);
    check("reti1_psw", PSW, 32'h000F_5000);
    tick();
    check("reti1_noack", ack_cnt, ack_snap);
    RETI = 1'b1; tick(); RETI = 1'b0;
    check("reti2_pc", REDIR_PC, 32'h0700_0180);
    check("reti2_psw", PSW, 32'h0003_0000);
    tick();

    // Simultaneous EXC + RETI + IRQ: exception only, IRQ later
    sr_wr(SR_PSW, 32'h0);
    EXC_REQ = 1'b1; EXC_CODE = 16'hFF60; CUR_PC = 32'h0700_0300;
    RETI = 1'b1; IRQ_REQ = 1'b1; IRQ_LEVEL = 4'd1;
    tick();
    EXC_REQ = 1'b0; RETI = 1'b0;
    check("sim_noreti", {31'd0, REDIR}, 32'd0);
    check("sim_busy", {31'd0, BUSY}, 32'd1);
    wait_redir("sim_exc_seen", ok);
    check("sim_exc_pc", REDIR_PC, 32'hFFFF_FF60);
    tick();
    check("sim_idle", {31'd0, BUSY}, 32'd0);
    sr_wr(SR_PSW, 32'h0);
    wait_redir("sim_irq_seen", ok);
    check("sim_irq_pc", REDIR_PC, 32'hFFFF_FE10);
    IRQ_REQ = 1'b0;
    tick();
    sr_chk("sim_psw", SR_PSW, 32'h0002_5000);

    // Fatal: exception with NP=1 halts
    sr_wr(SR_PSW, 32'h0000_8000);
    redir_snap = redir_cnt;
    EXC_REQ = 1'b1; EXC_CODE = 16'hFF60; CUR_PC = 32'h0700_0400;
    tick();
    EXC_REQ = 1'b0;
    repeat (5) tick();
    check("fatal_set", {31'd0, FATAL}, 32'd1);
    check("fatal_busy", {31'd0, BUSY}, 32'd1);
    check("fatal_noredir", redir_cnt, redir_snap);
    sr_chk("fatal_eipc_kept", SR_EIPC, 32'h0700_0300);
    RESn = 1'b0;
    #1;
    check("fatal_clr", {31'd0, FATAL}, 32'd0);
    check("fatal_busy_clr", {31'd0, BUSY}, 32'd0);
    check("fatal_psw_rst", PSW, 32'h0000_8000);
    @(negedge clk);
    RESn = 1'b1;

    // Clock enable low holds state
    CE = 1'b0;
    sr_wr(SR_PSW, 32'h0000_0001);
    EXC_REQ = 1'b1; tick(); EXC_REQ = 1'b0;
    check("ce_busy", {31'd0, BUSY}, 32'd0);
    CE = 1'b1;
    sr_chk("ce_psw", SR_PSW, 32'h0000_8000);

    // Address trap
    sr_wr(SR_ADTRE, 32'h0000_2001);
`ifdef V810_ADTRE_EN
    sr_chk("adtre_rd", SR_ADTRE, 32'h0000_2000);
    sr_wr(SR_PSW, 32'h0000_2000);
    CUR_PC = 32'h0000_2000;
    tick();
    CUR_PC = 32'h0700_0000;
    wait_redir("adtre_seen", ok);
    check("adtre_pc", REDIR_PC, 32'hFFFF_FFC0);
    tick();
    sr_chk("adtre_ecr", SR_ECR, 32'h0000_FFC0);
`else
    sr_chk("adtre_rd", SR_ADTRE, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
